// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the mini-rv RV32I pipeline:
//   - alu_op_e : 4-bit ALU operation encoding used by EX
//   - imm_fmt_e: immediate format selector used inside decode
//   - OPC_*    : major opcode values (instr[6:0])
//   - id_ex_t  : packed ID/EX pipeline bundle
//   - alu_op_from_funct(): funct3/funct7[5] to ALU operation
// ---------------------------------------------------------------------------
package rv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic [2:0]  funct3;
    logic        alu_src;
    logic        pc_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } id_ex_t;

  // is_op distinguishes register-register OP (funct7[5] selects SUB and SRA)
  // from OP-IMM (funct7[5] only selects SRA; ADDI has no subtract form).
  function automatic alu_op_e alu_op_from_funct(input logic [2:0] funct3,
                                                input logic       f7b5,
                                                input logic       is_op);
    alu_op_e op;
    case (funct3)
      3'd0:    op = (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = f7b5 ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
// 32 x 32-bit integer register file, x0 hard-wired to zero.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   i_rs1_addr/i_rs2_addr: read addresses (asynchronous read)
//   o_rs1_data/o_rs2_data: read data, with write-first bypass
//   i_we, i_rd_addr, i_wd: synchronous write port
// ---------------------------------------------------------------------------
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  input  logic        i_we,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_wd
);

  logic [31:0] r_regs [32];
  logic        w_wr_en;

  assign w_wr_en = i_we && (i_rd_addr != 5'd0);

  // NOTE: the whole array is reset because software may read any register
  // before writing it; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_rd_addr] <= i_wd;
    end
  end

  // Write-first: a same-cycle writeback is visible to decode before the edge.
  always_comb begin
    o_rs1_data = r_regs[i_rs1_addr];
    if (i_rs1_addr == 5'd0)                      o_rs1_data = '0;
    else if (w_wr_en && i_rd_addr == i_rs1_addr) o_rs1_data = i_wd;

    o_rs2_data = r_regs[i_rs2_addr];
    if (i_rs2_addr == 5'd0)                      o_rs2_data = '0;
    else if (w_wr_en && i_rd_addr == i_rs2_addr) o_rs2_data = i_wd;
  end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Instruction decode stage of the mini-rv 5-stage RV32I pipeline: register
// file, immediate generation, control decode, load-use hazard detection and
// wrong-path squashing after an EX redirect.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   if_id_instr_data, if_id_pc        : instruction and PC from fetch
//   ex_if_take_branch                 : EX redirect, IF/ID slot is wrong-path
//   wb_we, wb_rd, wb_data             : register file writeback
//   stall                             : combinational hold request to fetch
//   id_ex_*                           : registered ID/EX bundle
// ---------------------------------------------------------------------------
module decode_stage
  import rv_pkg::*;
#(
  parameter int KILL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_instr_data,
  input  logic [31:0] if_id_pc,
  input  logic        ex_if_take_branch,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        id_ex_valid,
  output logic [31:0] id_ex_pc,
  output logic [31:0] id_ex_rs1_data,
  output logic [31:0] id_ex_rs2_data,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rs1,
  output logic [4:0]  id_ex_rs2,
  output logic [4:0]  id_ex_rd,
  output logic [3:0]  id_ex_alu_op,
  output logic [2:0]  id_ex_funct3,
  output logic        id_ex_alu_src,
  output logic        id_ex_pc_src,
  output logic        id_ex_reg_write,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic        id_ex_branch,
  output logic        id_ex_jump,
  output logic        id_ex_illegal
);

  // Counter only ever holds KILL_CYCLES-1.
  localparam int KILL_W = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;

  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic        w_f7b5;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [31:0] w_imm;
  imm_fmt_e    w_imm_fmt;
  logic        w_rs1_used;
  logic        w_rs2_used;
  logic        w_kill;
  id_ex_t      w_dec;
  id_ex_t      r_id_ex;
  logic [KILL_W-1:0] r_kill_cnt;

  assign w_instr  = if_id_instr_data;
  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_funct3 = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_f7b5   = w_instr[30];

  regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_we       (wb_we),
    .i_rd_addr  (wb_rd),
    .i_wd       (wb_data)
  );

  // Immediate generation, all formats sign-extended from instr[31].
  always_comb begin
    case (w_imm_fmt)
      IMM_S:   w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      IMM_B:   w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                        w_instr[30:25], w_instr[11:8], 1'b0};
      IMM_U:   w_imm = {w_instr[31:12], 12'b0};
      IMM_J:   w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                        w_instr[20], w_instr[30:21], 1'b0};
      default: w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
    endcase
  end

  // Control decode. Flags default to 0 so FENCE falls out as a NOP and
  // SYSTEM/unknown opcodes only raise illegal.
  // NOTE: every signal driven here gets a default first, otherwise opcodes
  // not named in the case would infer latches.
  always_comb begin
    w_dec           = '0;
    w_imm_fmt       = IMM_I;
    w_rs1_used      = 1'b0;
    w_rs2_used      = 1'b0;
    w_dec.valid     = 1'b1;
    w_dec.pc        = if_id_pc;
    w_dec.rs1_data  = w_rs1_data;
    w_dec.rs2_data  = w_rs2_data;
    w_dec.rs1       = w_rs1;
    w_dec.rs2       = w_rs2;
    w_dec.rd        = w_rd;
    w_dec.funct3    = w_funct3;
    w_dec.alu_op    = ALU_ADD;
    case (w_opcode)
      OPC_LUI: begin
        w_imm_fmt       = IMM_U;
        w_dec.alu_op    = ALU_PASS_B;
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_imm_fmt       = IMM_U;
        w_dec.alu_src   = 1'b1;
        w_dec.pc_src    = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        w_imm_fmt       = IMM_J;
        w_dec.alu_src   = 1'b1;
        w_dec.pc_src    = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.jump      = 1'b1;
      end
      OPC_JALR: begin
        w_rs1_used      = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.pc_src    = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.jump      = 1'b1;
      end
      OPC_BRANCH: begin
        // EX compares rs1 against rs2; funct3 picks the condition.
        w_imm_fmt    = IMM_B;
        w_rs1_used   = 1'b1;
        w_rs2_used   = 1'b1;
        w_dec.alu_op = ALU_SUB;
        w_dec.branch = 1'b1;
      end
      OPC_LOAD: begin
        w_rs1_used      = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.mem_read  = 1'b1;
      end
      OPC_STORE: begin
        w_imm_fmt       = IMM_S;
        w_rs1_used      = 1'b1;
        w_rs2_used      = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
      end
      OPC_OP_IMM: begin
        w_rs1_used      = 1'b1;
        w_dec.alu_op    = alu_op_from_funct(w_funct3, w_f7b5, 1'b0);
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      OPC_OP: begin
        w_rs1_used      = 1'b1;
        w_rs2_used      = 1'b1;
        w_dec.alu_op    = alu_op_from_funct(w_funct3, w_f7b5, 1'b1);
        w_dec.reg_write = 1'b1;
      end
      OPC_FENCE: ;
      default: w_dec.illegal = 1'b1;
    endcase
    w_dec.imm = w_imm;
  end

  // The IF/ID slot is wrong-path in the redirect cycle and for the
  // following kill_cnt cycles.
  assign w_kill = ex_if_take_branch || (r_kill_cnt != '0);

  assign stall = r_id_ex.valid && r_id_ex.mem_read && (r_id_ex.rd != 5'd0) &&
                 ((w_rs1_used && (r_id_ex.rd == w_rs1)) ||
                  (w_rs2_used && (r_id_ex.rd == w_rs2))) &&
                 !w_kill;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kill_cnt <= '0;
    end else if (ex_if_take_branch) begin
      r_kill_cnt <= KILL_W'(KILL_CYCLES - 1);
    end else if (r_kill_cnt != '0) begin
      r_kill_cnt <= r_kill_cnt - 1'b1;
    end
  end

  // Kill and stall both insert an all-zero bubble; stall is already
  // suppressed under kill, so kill wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_ex <= '0;
    end else if (w_kill || stall) begin
      r_id_ex <= '0;
    end else begin
      r_id_ex <= w_dec;
    end
  end

  assign id_ex_valid     = r_id_ex.valid;
  assign id_ex_pc        = r_id_ex.pc;
  assign id_ex_rs1_data  = r_id_ex.rs1_data;
  assign id_ex_rs2_data  = r_id_ex.rs2_data;
  assign id_ex_imm       = r_id_ex.imm;
  assign id_ex_rs1       = r_id_ex.rs1;
  assign id_ex_rs2       = r_id_ex.rs2;
  assign id_ex_rd        = r_id_ex.rd;
  assign id_ex_alu_op    = r_id_ex.alu_op;
  assign id_ex_funct3    = r_id_ex.funct3;
  assign id_ex_alu_src   = r_id_ex.alu_src;
  assign id_ex_pc_src    = r_id_ex.pc_src;
  assign id_ex_reg_write = r_id_ex.reg_write;
  assign id_ex_mem_read  = r_id_ex.mem_read;
  assign id_ex_mem_write = r_id_ex.mem_write;
  assign id_ex_branch    = r_id_ex.branch;
  assign id_ex_jump      = r_id_ex.jump;
  assign id_ex_illegal   = r_id_ex.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Directed-vector bench for decode_stage (KILL_CYCLES = 2). Inputs change
// 1 time unit after each rising edge; outputs are checked before the next.
// ---------------------------------------------------------------------------
module tb_decode_stage;

  localparam logic [31:0] NOP       = 32'h00000013;
  localparam logic [31:0] ADDI_X1   = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] LW_X2     = 32'h0000A103; // lw   x2,0(x1)
  localparam logic [31:0] ADD_X3    = 32'h001101B3; // add  x3,x2,x1
  localparam logic [31:0] ADDI_X5   = 32'h00008293; // addi x5,x1,0
  localparam logic [31:0] SW_X2     = 32'hFE20AE23; // sw   x2,-4(x1)
  localparam logic [31:0] JAL_X1    = 32'h010000EF; // jal  x1,16
  localparam logic [31:0] LUI_X5    = 32'h123452B7; // lui  x5,0x12345
  localparam logic [31:0] SRAI_X6   = 32'h4030D313; // srai x6,x1,3
  localparam logic [31:0] ADD_X3_X0 = 32'h000001B3; // add  x3,x0,x0
  localparam logic [31:0] ECALL     = 32'h00000073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id_instr_data;
  logic [31:0] if_id_pc;
  logic        ex_if_take_branch;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc;
  logic [31:0] id_ex_rs1_data;
  logic [31:0] id_ex_rs2_data;
  logic [31:0] id_ex_imm;
  logic [4:0]  id_ex_rs1;
  logic [4:0]  id_ex_rs2;
  logic [4:0]  id_ex_rd;
  logic [3:0]  id_ex_alu_op;
  logic [2:0]  id_ex_funct3;
  logic        id_ex_alu_src;
  logic        id_ex_pc_src;
  logic        id_ex_reg_write;
  logic        id_ex_mem_read;
  logic        id_ex_mem_write;
  logic        id_ex_branch;
  logic        id_ex_jump;
  logic        id_ex_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage #(.KILL_CYCLES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_id_instr_data  (if_id_instr_data),
    .if_id_pc          (if_id_pc),
    .ex_if_take_branch (ex_if_take_branch),
    .wb_we             (wb_we),
    .wb_rd             (wb_rd),
    .wb_data           (wb_data),
    .stall             (stall),
    .id_ex_valid       (id_ex_valid),
    .id_ex_pc          (id_ex_pc),
    .id_ex_rs1_data    (id_ex_rs1_data),
    .id_ex_rs2_data    (id_ex_rs2_data),
    .id_ex_imm         (id_ex_imm),
    .id_ex_rs1         (id_ex_rs1),
    .id_ex_rs2         (id_ex_rs2),
    .id_ex_rd          (id_ex_rd),
    .id_ex_alu_op      (id_ex_alu_op),
    .id_ex_funct3      (id_ex_funct3),
    .id_ex_alu_src     (id_ex_alu_src),
    .id_ex_pc_src      (id_ex_pc_src),
    .id_ex_reg_write   (id_ex_reg_write),
    .id_ex_mem_read    (id_ex_mem_read),
    .id_ex_mem_write   (id_ex_mem_write),
    .id_ex_branch      (id_ex_branch),
    .id_ex_jump        (id_ex_jump),
    .id_ex_illegal     (id_ex_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and let combinational logic settle.
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    if_id_instr_data = instr;
    if_id_pc         = pc;
    #1;
  endtask

  function automatic logic [6:0] ctrl_flags();
    return {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch,
            id_ex_jump, id_ex_alu_src, id_ex_pc_src};
  endfunction

  initial begin
    rst               = 1'b1;
    if_id_instr_data  = NOP;
    if_id_pc          = 32'h0;
    ex_if_take_branch = 1'b0;
    wb_we             = 1'b0;
    wb_rd             = 5'd0;
    wb_data           = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(id_ex_valid), 32'd0);
    check("rst_pc",    id_ex_pc, 32'h0);
    check("rst_flags", 32'(ctrl_flags()), 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    // addi x1,x0,5
    drive(ADDI_X1, 32'h100);
    step();
    check("addi_valid", 32'(id_ex_valid), 32'd1);
    check("addi_rd",    32'(id_ex_rd), 32'd1);
    check("addi_imm",   id_ex_imm, 32'd5);
    check("addi_aluop", 32'(id_ex_alu_op), 32'd0);
    check("addi_flags", 32'(ctrl_flags()), 32'b1000010);
    check("addi_pc",    id_ex_pc, 32'h100);

    // Load-use: lw x2 then add x3,x2,x1
    drive(LW_X2, 32'h104);
    step();
    check("lw_flags", 32'(ctrl_flags()), 32'b1100010);
    check("lw_rd",    32'(id_ex_rd), 32'd2);
    drive(ADD_X3, 32'h108);
    check("lu_stall", 32'(stall), 32'd1);
    step();
    check("lu_bubble_valid", 32'(id_ex_valid), 32'd0);
    check("lu_bubble_flags", 32'(ctrl_flags()), 32'h0);
    check("lu_stall_clear",  32'(stall), 32'd0);
    // Writeback to x1 in the cycle add is re-decoded: bypass path
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
    step();
    wb_we = 1'b0;
    check("add_valid",   32'(id_ex_valid), 32'd1);
    check("add_rs1",     32'(id_ex_rs1), 32'd2);
    check("add_rs2",     32'(id_ex_rs2), 32'd1);
    check("add_rd",      32'(id_ex_rd), 32'd3);
    check("add_bypass",  id_ex_rs2_data, 32'h1234);
    check("add_alu_src", 32'(id_ex_alu_src), 32'd0);
    check("add_pc",      id_ex_pc, 32'h108);

    // Write persisted after the edge
    drive(ADDI_X5, 32'h10C);
    step();
    check("x1_persist", id_ex_rs1_data, 32'h1234);

    // Store immediate
    drive(SW_X2, 32'h110);
    step();
    check("sw_imm",   id_ex_imm, 32'hFFFFFFFC);
    check("sw_flags", 32'(ctrl_flags()), 32'b0010010);
    check("sw_rs2",   32'(id_ex_rs2), 32'd2);

    // JAL immediate
    drive(JAL_X1, 32'h114);
    step();
    check("jal_imm",   id_ex_imm, 32'h10);
    check("jal_flags", 32'(ctrl_flags()), 32'b1000111);

    // LUI: U immediate, PASS_B
    drive(LUI_X5, 32'h118);
    step();
    check("lui_imm",   id_ex_imm, 32'h12345000);
    check("lui_aluop", 32'(id_ex_alu_op), 32'd10);

    // SRAI: funct7[5] selects SRA on OP-IMM shifts
    drive(SRAI_X6, 32'h11C);
    step();
    check("srai_aluop", 32'(id_ex_alu_op), 32'd7);

    // Write to x0 is ignored, both bypass and storage
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    drive(ADD_X3_X0, 32'h120);
    step();
    wb_we = 1'b0;
    check("x0_bypass", id_ex_rs1_data, 32'h0);
    step();
    check("x0_stored", id_ex_rs1_data, 32'h0);

    // ECALL -> illegal only
    drive(ECALL, 32'h124);
    step();
    check("ecall_illegal", 32'(id_ex_illegal), 32'd1);
    check("ecall_flags",   32'(ctrl_flags()), 32'h0);
    check("ecall_valid",   32'(id_ex_valid), 32'd1);

    // Kill with KILL_CYCLES=2: two bubbles
    ex_if_take_branch = 1'b1;
    drive(ADD_X3, 32'h200);
    step();
    ex_if_take_branch = 1'b0;
    check("kill_b1", 32'(id_ex_valid), 32'd0);
    step();
    check("kill_b2", 32'(id_ex_valid), 32'd0);
    step();
    check("kill_done_valid", 32'(id_ex_valid), 32'd1);
    check("kill_done_rd",    32'(id_ex_rd), 32'd3);

    // Kill overrides a load-use stall
    drive(LW_X2, 32'h300);
    step();
    ex_if_take_branch = 1'b1;
    drive(ADD_X3, 32'h304);
    check("kill_lu_stall", 32'(stall), 32'd0);
    step();
    ex_if_take_branch = 1'b0;
    check("kill_lu_b1", 32'(id_ex_valid), 32'd0);
    step();
    check("kill_lu_b2", 32'(id_ex_valid), 32'd0);
    step();
    check("kill_lu_after", 32'(id_ex_rd), 32'd3);

    // Reset mid-stall clears everything immediately
    drive(LW_X2, 32'h400);
    step();
    drive(ADD_X3, 32'h404);
    check("pre_rst_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(id_ex_valid), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_pc",    id_ex_pc, 32'h0);
    check("mid_rst_rd",    32'(id_ex_rd), 32'd0);
    step();
    rst = 1'b0;
    drive(ADDI_X5, 32'h408);
    step();
    check("rst_regfile_x1", id_ex_rs1_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
